// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, flit type codes, head-flit field layout
// and the NI transmit FSM state type.
package noc_pkg;
  localparam int FLIT_W = 35;
  localparam int PLD_W  = 32;

  localparam logic [2:0] FT_HEAD = 3'b001;
  localparam logic [2:0] FT_BODY = 3'b010;
  localparam logic [2:0] FT_TAIL = 3'b100;

  // Head payload field LSB positions; [23:0] are reserved and zero
  localparam int HD_DSTX_LSB = 30;
  localparam int HD_DSTY_LSB = 28;
  localparam int HD_SRCX_LSB = 26;
  localparam int HD_SRCY_LSB = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // Build the head payload from destination and source coordinates
  function automatic logic [PLD_W-1:0] head_pld(input logic [1:0] dx, input logic [1:0] dy,
                                                input logic [1:0] sx, input logic [1:0] sy);
    logic [PLD_W-1:0] p;
    p = '0;
    p[HD_DSTX_LSB +: 2] = dx;
    p[HD_DSTY_LSB +: 2] = dy;
    p[HD_SRCX_LSB +: 2] = sx;
    p[HD_SRCY_LSB +: 2] = sy;
    return p;
  endfunction
endpackage

// File: rtl/ni_tx_credit.sv
// Per-VC credit counter: counts free slots in the router input buffer.
// Range 0..CREDITS; an ack arriving at full credit without a same-cycle launch
// is dropped and reported on ovf_o for one cycle.
module ni_tx_credit #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch_i,
  input  logic ack_i,
  output logic empty_o,
  output logic ovf_o
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full;

  assign full    = (cnt_q == CMAX);
  assign empty_o = (cnt_q == '0);

  // Next credit count; launch+ack in the same cycle cancel out
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    case ({launch_i, ack_i})
      2'b10: cnt_d = cnt_q - CW'(1);
      2'b01: begin
        if (full) ovf_o = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Credit register, full after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CMAX;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ni_flit_tx.sv
// NI transmit side: packetizes local payload beats into head/body/tail flits
// over two credit-controlled VCs with round-robin VC choice per packet.
// Optional: define NI_TX_STATS_EN to add the PKT_CNT tail counter output.
module ni_flit_tx
  import noc_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              RST_,
  input  logic [1:0]        MY_XPOS,
  input  logic [1:0]        MY_YPOS,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [31:0]       S_DATA,
  input  logic              S_LAST,
  input  logic [1:0]        S_DSTX,
  input  logic [1:0]        S_DSTY,
  output logic [FLIT_W-1:0] ODATA,
  output logic              OVALID,
  output logic              OVCH,
  input  logic [1:0]        IACK,
  input  logic [1:0]        IRDY,
  input  logic [1:0]        ILCK,
  output logic              CRED_ERR
`ifdef NI_TX_STATS_EN
  ,
  output logic [15:0]       PKT_CNT
`endif
);
  tx_state_e         state_q;
  logic              vc_q, rr_q, err_q, ovalid_q, ovch_q;
  logic [FLIT_W-1:0] odata_q, flit_d;
  logic [1:0]        empty, ovf, elig, launch_v;
  logic              pick_vc, launch_vc, start, beat, launch, s_ready;

  // A VC may take a new packet only if free, unlocked and holding a credit
  assign elig     = IRDY & ~ILCK & ~empty;
  assign s_ready  = (state_q == ST_SEND) && !empty[vc_q];
  assign start    = (state_q == ST_IDLE) && S_VALID && (|elig);
  assign beat     = S_VALID && s_ready;
  assign launch   = start || beat;
  assign launch_vc = (state_q == ST_IDLE) ? pick_vc : vc_q;
  assign launch_v = {launch && launch_vc, launch && !launch_vc};

  // VC choice: the single eligible VC, or the RR pointer when both are eligible
  always_comb begin
    pick_vc = elig[1];
    if (elig == 2'b11) pick_vc = rr_q;
  end

  // Flit being launched this cycle (head carries routing info, beats carry data)
  always_comb begin
    flit_d = {S_LAST ? FT_TAIL : FT_BODY, S_DATA};
    if (state_q == ST_IDLE) flit_d = {FT_HEAD, head_pld(S_DSTX, S_DSTY, MY_XPOS, MY_YPOS)};
  end

  for (genvar v = 0; v < 2; v++) begin : g_cred
    ni_tx_credit #(.CREDITS(CREDITS)) u_cred (
      .clk      (clk),
      .rst_n    (RST_),
      .launch_i (launch_v[v]),
      .ack_i    (IACK[v]),
      .empty_o  (empty[v]),
      .ovf_o    (ovf[v])
    );
  end

  // Packet FSM, registered flit output and sticky credit error
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      state_q  <= ST_IDLE;
      vc_q     <= 1'b0;
      rr_q     <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ovalid_q <= launch;
      err_q    <= err_q | (|ovf);
      if (launch) begin
        odata_q <= flit_d;
        ovch_q  <= launch_vc;
      end
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_SEND;
          vc_q    <= pick_vc;
        end
        ST_SEND: if (beat && S_LAST) begin
          state_q <= ST_IDLE;
          rr_q    <= ~vc_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef NI_TX_STATS_EN
  logic [15:0] pkt_cnt_q;

  // Saturating count of tails sent
  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_)                                        pkt_cnt_q <= '0;
    else if (beat && S_LAST && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign PKT_CNT = pkt_cnt_q;
`endif

  assign S_READY  = s_ready;
  assign ODATA    = odata_q;
  assign OVALID   = ovalid_q;
  assign OVCH     = ovch_q;
  assign CRED_ERR = err_q;
endmodule

// File: tb/tb_ni_flit_tx.sv
// Bench for ni_flit_tx: directed scenarios plus random traffic, all checked
// against a packet-level reference model kept in the bench.
module tb_ni_flit_tx;
  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        RST_;
  logic [1:0]  MY_XPOS, MY_YPOS;
  logic        S_VALID, S_READY, S_LAST;
  logic [31:0] S_DATA;
  logic [1:0]  S_DSTX, S_DSTY;
  logic [34:0] ODATA;
  logic        OVALID, OVCH, CRED_ERR;
  logic [1:0]  IACK, IRDY, ILCK;
`ifdef NI_TX_STATS_EN
  logic [15:0] PKT_CNT;
`endif

  always #5 clk = ~clk;

  ni_flit_tx #(.CREDITS(CREDITS)) dut (
    .clk(clk), .RST_(RST_), .MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_LAST(S_LAST),
    .S_DSTX(S_DSTX), .S_DSTY(S_DSTY), .ODATA(ODATA), .OVALID(OVALID), .OVCH(OVCH),
    .IACK(IACK), .IRDY(IRDY), .ILCK(ILCK), .CRED_ERR(CRED_ERR)
`ifdef NI_TX_STATS_EN
    , .PKT_CNT(PKT_CNT)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: packet in progress or not, its VC, RR preference,
  // free buffer slots per VC, and the expected registered outputs.
  bit          m_busy, m_vc, m_rr, m_err, m_acc;
  int          m_cred[2];
  int          m_pkts;
  logic [34:0] m_odata;
  bit          m_ovalid, m_ovch;
  int          flits_seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_vc = 0; m_rr = 0; m_err = 0; m_acc = 0;
    m_cred[0] = CREDITS; m_cred[1] = CREDITS;
    m_pkts = 0; m_odata = '0; m_ovalid = 0; m_ovch = 0;
  endtask

  task automatic drive_idle();
    S_VALID = 0; S_LAST = 0; S_DATA = '0; S_DSTX = '0; S_DSTY = '0;
    IACK = '0; IRDY = '0; ILCK = '0;
  endtask

  // Reset pulse entered and left on a negedge; reset values checked while asserted
  task automatic do_reset();
    drive_idle();
    RST_ = 1'b0;
    #1;
    model_reset();
    check("rst_ovalid", OVALID, 0);
    check("rst_odata", ODATA, 0);
    check("rst_ovch", OVCH, 0);
    check("rst_err", CRED_ERR, 0);
    check("rst_ready", S_READY, 0);
`ifdef NI_TX_STATS_EN
    check("rst_pktcnt", PKT_CNT, 0);
`endif
    @(negedge clk);
    RST_ = 1'b1;
  endtask

  // One clock cycle: apply inputs at the negedge, predict, compare at the next negedge
  task automatic cyc(input bit sv, input bit sl, input logic [31:0] sd,
                     input logic [1:0] dx, input logic [1:0] dy,
                     input logic [1:0] irdy, input logic [1:0] ilck, input logic [1:0] iack);
    bit exp_rdy, launched, lvc, e0, e1;
    logic [34:0] f;
    S_VALID = sv; S_LAST = sl; S_DATA = sd; S_DSTX = dx; S_DSTY = dy;
    IRDY = irdy; ILCK = ilck; IACK = iack;
    #1;
    exp_rdy = m_busy && (m_cred[m_vc] > 0);
    check("s_ready", S_READY, exp_rdy);
    launched = 0; lvc = 0; f = '0; m_acc = 0;
    if (!m_busy) begin
      e0 = irdy[0] && !ilck[0] && m_cred[0] > 0;
      e1 = irdy[1] && !ilck[1] && m_cred[1] > 0;
      if (sv && (e0 || e1)) begin
        lvc = (e0 && e1) ? m_rr : e1;
        launched = 1;
        f = {3'b001, dx, dy, MY_XPOS, MY_YPOS, 24'd0};
        m_busy = 1; m_vc = lvc;
      end
    end else if (sv && exp_rdy) begin
      lvc = m_vc; launched = 1; m_acc = 1;
      f = {sl ? 3'b100 : 3'b010, sd};
      if (sl) begin
        m_busy = 0; m_rr = !m_vc;
        if (m_pkts < 65535) m_pkts++;
      end
    end
    for (int v = 0; v < 2; v++) begin
      m_cred[v] = m_cred[v] + int'(iack[v]) - int'(launched && lvc == v);
      if (m_cred[v] > CREDITS) begin m_cred[v] = CREDITS; m_err = 1; end
    end
    m_ovalid = launched;
    if (launched) begin m_odata = f; m_ovch = lvc; end
    @(negedge clk);
    check("ovalid", OVALID, m_ovalid);
    check("odata", ODATA, m_odata);
    check("ovch", OVCH, m_ovch);
    check("cred_err", CRED_ERR, m_err);
`ifdef NI_TX_STATS_EN
    check("pkt_cnt", PKT_CNT, m_pkts[15:0]);
`endif
    if (OVALID) flits_seen++;
  endtask

  // Return credits to VC v until full, while idle
  task automatic refill();
    for (int k = 0; k < 2 * CREDITS; k++) begin
      logic [1:0] a;
      a = {m_cred[1] < CREDITS, m_cred[0] < CREDITS};
      cyc(0, 0, 0, 0, 0, 2'b11, 0, a);
    end
  endtask

  initial begin
    int b;
    MY_XPOS = 2'd0; MY_YPOS = 2'd0;
    drive_idle();
    RST_ = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 3-beat packet, dst (2,1), local (0,0)
    cyc(1, 0, 32'hA0, 2'd2, 2'd1, 2'b11, 0, 0);
    check("t1_head", ODATA, 35'h1_9000_0000);
    check("t1_head_vc", OVCH, 0);
    check("t1_head_vld", OVALID, 1);
    cyc(1, 0, 32'hA0, 2'd2, 2'd1, 2'b11, 0, 0);
    check("t1_body0", ODATA, {3'b010, 32'hA0});
    cyc(1, 0, 32'hA1, 2'd2, 2'd1, 2'b11, 0, 0);
    check("t1_body1", ODATA, {3'b010, 32'hA1});
    cyc(1, 1, 32'hA2, 2'd2, 2'd1, 2'b11, 0, 0);
    check("t1_tail", ODATA, {3'b100, 32'hA2});
    check("t1_tail_vc", OVCH, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 0, 0);
    check("t1_gap", OVALID, 0);
    refill();

    // Credit stall: 6 beats with no acks gives 4 flits, one ack releases one more
    do_reset();
    flits_seen = 0; b = 0;
    repeat (12) begin
      cyc(1, b == 5, 32'(b), 2'd1, 2'd1, 2'b11, 0, 0);
      if (m_acc) b++;
    end
    check("t2_flits", flits_seen, 4);
    check("t2_stall_ready", S_READY, 0);
    cyc(1, b == 5, 32'(b), 2'd1, 2'd1, 2'b11, 0, 2'b01);
    if (m_acc) b++;
    repeat (5) begin
      cyc(1, b == 5, 32'(b), 2'd1, 2'd1, 2'b11, 0, 0);
      if (m_acc) b++;
    end
    check("t2_flits_after_ack", flits_seen, 5);
    for (int k = 0; k < 40 && b < 6; k++) begin
      cyc(1, b == 5, 32'(b), 2'd1, 2'd1, 2'b11, 0, {1'b0, m_cred[0] < CREDITS});
      if (m_acc) b++;
    end
    check("t2_done", b, 6);
    refill();

    // Back-to-back single-beat packets alternate VCs
    do_reset();
    cyc(1, 1, 32'h11, 2'd3, 2'd0, 2'b11, 0, 0);
    check("t3_p1_vc", OVCH, 0);
    cyc(1, 1, 32'h11, 2'd3, 2'd0, 2'b11, 0, 0);
    cyc(1, 1, 32'h22, 2'd0, 2'd3, 2'b11, 0, 0);
    check("t3_p2_head", ODATA[34:32], 3'b001);
    check("t3_p2_vc", OVCH, 1);
    cyc(1, 1, 32'h22, 2'd0, 2'd3, 2'b11, 0, 0);
    check("t3_p2_tail_vc", OVCH, 1);

    // Locked VC blocks the head until unlocked
    do_reset();
    flits_seen = 0;
    repeat (3) cyc(1, 1, 32'h33, 2'd1, 2'd2, 2'b01, 2'b01, 0);
    check("t4_locked", flits_seen, 0);
    cyc(1, 1, 32'h33, 2'd1, 2'd2, 2'b01, 2'b00, 0);
    check("t4_head_vld", OVALID, 1);
    check("t4_head_vc", OVCH, 0);
    cyc(1, 1, 32'h33, 2'd1, 2'd2, 2'b01, 2'b00, 0);

    // Launch+ack cancel; ack at full credit raises a sticky error
    do_reset();
    cyc(1, 1, 32'h44, 2'd2, 2'd2, 2'b01, 0, 2'b01);
    check("t5_no_err", CRED_ERR, 0);
    cyc(1, 1, 32'h44, 2'd2, 2'd2, 2'b01, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b01, 0, 2'b01);
    check("t5_refilled_no_err", CRED_ERR, 0);
    cyc(0, 0, 0, 0, 0, 2'b01, 0, 2'b01);
    check("t5_err", CRED_ERR, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, 2'b01, 0, 0);
    check("t5_err_sticky", CRED_ERR, 1);

    // Reset in the middle of a packet
    do_reset();
    cyc(1, 0, 32'h55, 2'd1, 2'd3, 2'b11, 0, 0);
    cyc(1, 0, 32'h55, 2'd1, 2'd3, 2'b11, 0, 0);
    check("t6_body_vld", OVALID, 1);
    RST_ = 1'b0;
    #1;
    check("t6_rst_ovalid", OVALID, 0);
    check("t6_rst_odata", ODATA, 0);
    model_reset();
    @(negedge clk);
    RST_ = 1'b1;
    cyc(1, 1, 32'h66, 2'd1, 2'd3, 2'b11, 0, 0);
    check("t6_new_head", ODATA[34:32], 3'b001);
    cyc(1, 1, 32'h66, 2'd1, 2'd3, 2'b11, 0, 0);
    check("t6_tail", ODATA, {3'b100, 32'h66});

    // Random traffic against the model
    MY_XPOS = 2'($urandom); MY_YPOS = 2'($urandom);
    do_reset();
    begin
      bit sv, sl;
      int len, bi;
      logic [31:0] sd;
      logic [1:0] dx, dy, irdy, ilck, iack;
      sv = 0; len = 1 + $urandom_range(0, 5); bi = 0;
      sd = $urandom; dx = 2'($urandom); dy = 2'($urandom);
      for (int c = 0; c < 3000; c++) begin
        if (!sv) sv = ($urandom_range(0, 3) != 0);
        sl = (bi == len - 1);
        irdy = 2'($urandom); ilck = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
        for (int v = 0; v < 2; v++)
          iack[v] = (m_cred[v] < CREDITS && $urandom_range(0, 2) == 0) ||
                    ($urandom_range(0, 255) == 0);
        cyc(sv, sl, sd, dx, dy, irdy, ilck, iack);
        if (m_acc) begin
          sv = 0; sd = $urandom; bi++;
          if (sl) begin
            bi = 0; len = 1 + $urandom_range(0, 5);
            dx = 2'($urandom); dy = 2'($urandom);
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ni_flit_tx.md
NI_FLIT_TX -- requirements
Module: ni_flit_tx

Interface
REQ-001 Parameter CREDITS, default 4, sets the router input buffer depth per VC and the initial credit count.
REQ-002 clk  in  1  single clock; all state rises on posedge.
REQ-003 RST_  in  1  reset, asynchronous and active-low.
REQ-004 MY_XPOS / MY_YPOS  in  2 / 2  local node coordinates, inserted as source in the head flit.
REQ-005 S_VALID / S_READY  in / out  1 / 1  local payload beat handshake.
REQ-006 S_DATA  in  32  payload beat.
REQ-007 S_LAST  in  1  marks the final beat of a packet.
REQ-008 S_DSTX / S_DSTY  in  2 / 2  destination; stable while S_VALID is high.
REQ-009 ODATA  out  35  flit to router input port: [34:32] type, [31:0] payload.
REQ-010 OVALID / OVCH  out  1 / 1  flit valid, one cycle per flit; VC of the flit.
REQ-011 IACK / IRDY / ILCK  in  2 / 2 / 2  per-VC signals: credit-return pulse; VC free to start a packet; VC locked.
REQ-012 CRED_ERR  out  1  sticky flag: IACK received while credits were full.

Function
REQ-013 Type encoding: head 3'b001, body 3'b010, tail 3'b100.
REQ-014 Head payload layout: [31:30]=S_DSTX, [29:28]=S_DSTY, [27:26]=MY_XPOS, [25:24]=MY_YPOS, [23:0]=0.
REQ-015 Each packet shall be one head flit followed by one flit per source beat; non-last beats are body flits, the S_LAST beat is a tail flit.
REQ-016 FSM states: IDLE, SEND.
REQ-017 In IDLE, S_READY shall be 0.
REQ-018 IDLE->SEND when S_VALID=1 and an eligible VC exists (IRDY[v]=1, ILCK[v]=0, credit[v]>0); the head flit is emitted on that VC and v is latched.
REQ-019 With both VCs eligible, selection follows a round-robin pointer (reset to VC0) that advances past the used VC when the tail is sent.
REQ-020 In SEND, S_READY=(credit[vc]>0) combinationally; each accepted beat emits a body or tail flit on the latched VC.
REQ-021 SEND->IDLE on acceptance of the S_LAST beat; IRDY/ILCK are ignored while in SEND.
REQ-022 ODATA/OVALID/OVCH shall be registered; a flit appears exactly one cycle after its accept/launch cycle, OVALID=0 otherwise; ODATA/OVCH hold their last value while OVALID=0.
REQ-023 credit[v] decrements on each flit launched on v and increments on each IACK[v] pulse; a simultaneous launch and ack leaves credit[v] unchanged.
REQ-024 Credit range is 0..CREDITS; an IACK that would exceed CREDITS is dropped and sets CRED_ERR.
REQ-025 At credit[vc]=0 in SEND, the packet stalls with S_READY=0 until an IACK arrives, and no other packet may interleave.

Reset
REQ-026 RST_ low asynchronously forces: state IDLE, credits=CREDITS, RR pointer=VC0, ODATA=0, OVALID=0, OVCH=0, CRED_ERR=0, S_READY=0.
REQ-027 Reset mid-packet discards the partial packet; no tail is generated after reset release.

Configuration
REQ-028 With NI_TX_STATS_EN defined, output PKT_CNT[15:0] counts tails sent (saturating at 16'hFFFF, reset 0); without the macro the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-029 Package noc_pkg shall hold the flit width (35), the type encodings, the head field positions and the FSM state typedef.
REQ-030 Sub-module ni_tx_credit (one per VC) shall implement the credit counter, its full/empty flags and the overflow detection.

Verification
REQ-031 Reset, IRDY=2'b11, ILCK=0, 3-beat packet with dst (2,1) at MY(0,0) -> flits 001/{2'd2,2'd1,2'd0,2'd0,24'd0}, 010, 010, 100, all on OVCH=0, each one cycle after its accept.
REQ-032 CREDITS=4, IACK held 0, 6-beat packet -> 4 flits, then S_READY=0; one IACK[vc] pulse -> exactly one more flit.
REQ-033 Two back-to-back single-beat packets with both VCs eligible -> first packet on VC0, second on VC1.
REQ-034 IRDY=2'b01, ILCK=2'b01 -> no head launched; release ILCK[0] -> head on VC0 the next cycle.
REQ-035 IACK[0] pulse at full credit -> CRED_ERR=1 and stays 1; launch and IACK on the same cycle -> credit unchanged.
REQ-036 RST_ asserted mid-packet -> OVALID=0 immediately, credits=4, state IDLE, with NI_TX_STATS_EN PKT_CNT=0.
